// File: rtl/dual_edge_capture.sv
// dual_edge_capture: pairs DDR beats (A on falling edge, B on rising edge) into words and buffers them in a FIFO
// Ports: clk_i/arst_ni clock and async active-low reset; ddr_valid_i/ddr_data_i DDR beat input;
//   clear_i clears sticky flags and drop counter; m_data_o/m_valid_o/m_ready_i output stream {B,A};
//   count_o FIFO occupancy; ovf_o/misalign_o sticky flags; drop_cnt_o dropped-pair counter.
// Macro DUAL_EDGE_CAPTURE_DROP_CNT_EN builds the saturating drop counter; otherwise drop_cnt_o is 0.
module dual_edge_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       ddr_valid_i,
  input  logic [WIDTH-1:0]           ddr_data_i,
  input  logic                       clear_i,
  output logic [2*WIDTH-1:0]         m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  output logic                       misalign_o,
  output logic [15:0]                drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] neg_data_q, neg_data_d;
  logic neg_valid_q, neg_valid_d, armed_q, armed_d;
  logic [2*WIDTH-1:0] pair_data_q, pair_data_d, last_q, last_d;
  logic pair_vld_q, pair_vld_d, ovf_q, ovf_d, mis_q, mis_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic pop, space, push, ovf_evt, mis_evt;
  // armed_q marks that a falling edge has been sampled since reset, so the
  // first rising edge after release cannot report a bogus misalignment
  always_comb begin
    neg_data_d = ddr_data_i;
    neg_valid_d = ddr_valid_i;
    armed_d = 1'b1;
  end
  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      neg_data_q <= '0;
      neg_valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      neg_data_q <= neg_data_d;
      neg_valid_q <= neg_valid_d;
      armed_q <= armed_d;
    end
  end
  always_comb begin
    pop = (count_q != '0) & m_ready_i;
    space = (count_q != CW'(DEPTH)) | pop;
    push = pair_vld_q & space;
    ovf_evt = pair_vld_q & ~space;
    mis_evt = armed_q & (ddr_valid_i ^ neg_valid_q);
    pair_data_d = {ddr_data_i, neg_data_q};
    pair_vld_d = ddr_valid_i & neg_valid_q;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = pair_data_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
    ovf_d = ovf_evt | (ovf_q & ~clear_i);
    mis_d = mis_evt | (mis_q & ~clear_i);
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pair_data_q <= '0;
      pair_vld_q <= 1'b0;
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pair_data_q <= pair_data_d;
      pair_vld_q <= pair_vld_d;
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end
  // when empty, the output keeps showing the most recently popped word
  assign m_valid_o = count_q != '0;
  assign m_data_o = m_valid_o ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;
  assign ovf_o = ovf_q;
  assign misalign_o = mis_q;
`ifdef DUAL_EDGE_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;
  // an overflow of the previous pair and a misaligned current pair can land on the same edge
  always_comb begin
    drop_sum = {1'b0, clear_i ? 16'd0 : drop_q} + 17'(ovf_evt) + 17'(mis_evt);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dual_edge_capture.sv
// tb_dual_edge_capture: table-driven, directed and randomized checks of dual_edge_capture against a queue model
module tb_dual_edge_capture;
  localparam int W = 8;
  localparam int D = 4;
`ifdef DUAL_EDGE_CAPTURE_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic ddr_valid = 1'b0;
  logic [W-1:0] ddr_data = '0;
  logic clear = 1'b0;
  logic m_ready = 1'b0;
  logic [2*W-1:0] m_data;
  logic m_valid, ovf, mis;
  logic [$clog2(D):0] count;
  logic [15:0] drop_cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dual_edge_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .arst_ni(arst_n), .ddr_valid_i(ddr_valid), .ddr_data_i(ddr_data),
    .clear_i(clear), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .count_o(count), .ovf_o(ovf), .misalign_o(mis), .drop_cnt_o(drop_cnt)
  );
  // reference model: beat A latch, pending pair, word queue, flags and drop total
  bit ma_v, m_armed, pend_v, m_ovf, m_mis;
  logic [W-1:0] ma_d;
  logic [2*W-1:0] pend_w, m_last;
  logic [2*W-1:0] q[$];
  int m_drops;
  always @(negedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ma_v = 0; ma_d = '0; m_armed = 0;
    end else begin
      ma_v = ddr_valid; ma_d = ddr_data; m_armed = 1;
    end
  end
  always @(posedge clk or negedge arst_n) begin
    bit pop_e, ovf_e, mis_e;
    if (!arst_n) begin
      q.delete(); pend_v = 0; pend_w = '0; m_last = '0; m_ovf = 0; m_mis = 0; m_drops = 0;
    end else begin
      pop_e = q.size() > 0 && m_ready;
      if (pop_e) m_last = q.pop_front();
      ovf_e = 0;
      if (pend_v) begin
        if (q.size() < D) q.push_back(pend_w);
        else ovf_e = 1;
      end
      mis_e = m_armed && (ma_v != ddr_valid);
      if (clear) begin m_ovf = 0; m_mis = 0; m_drops = 0; end
      m_ovf = m_ovf | ovf_e;
      m_mis = m_mis | mis_e;
      m_drops = m_drops + int'(ovf_e) + int'(mis_e);
      if (m_drops > 65535) m_drops = 65535;
      pend_v = ma_v && ddr_valid;
      pend_w = {ddr_data, ma_d};
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("m_data", 32'(m_data), 32'(q.size() != 0 ? q[0] : m_last));
    chk("count", 32'(count), 32'(q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("misalign", 32'(mis), 32'(m_mis));
    chk("drop_cnt", 32'(drop_cnt), CNT_EN ? 32'(m_drops) : 32'd0);
  endtask
  // beat A is driven after a rising edge, beat B after the following falling edge;
  // outputs are compared at that falling edge, away from the rising edge that changes them
  task automatic step(input bit va, input logic [W-1:0] a, input bit vb, input logic [W-1:0] b,
                      input bit rdy, input bit clr);
    @(posedge clk); #1;
    ddr_valid = va; ddr_data = a; m_ready = rdy; clear = clr;
    @(negedge clk);
    check_model();
    #1;
    ddr_valid = vb; ddr_data = b;
  endtask
  task automatic do_reset();
    @(posedge clk); #3;
    ddr_valid = 0; ddr_data = '0; m_ready = 0; clear = 0;
    arst_n = 0;
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk); #2;
    arst_n = 1;
  endtask
  typedef struct {
    bit va; logic [7:0] a; bit vb; logic [7:0] b; bit rdy; bit clr;
    int cnt; bit vld; bit ovf; bit mis; int drop;
  } vec_t;
  vec_t tbl[16];
  initial begin
    tbl[0]  = '{1, 8'h10, 1, 8'h20, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 8'h11, 1, 8'h21, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 8'h12, 1, 8'h22, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 8'h13, 1, 8'h23, 0, 0, 2, 1, 0, 0, 0};
    tbl[4]  = '{1, 8'h14, 1, 8'h24, 0, 0, 3, 1, 0, 0, 0};
    tbl[5]  = '{1, 8'h15, 1, 8'h25, 0, 0, 4, 1, 0, 0, 0};
    tbl[6]  = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 1, 0, 1};
    tbl[7]  = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 1, 0, 2};
    tbl[8]  = '{1, 8'hAA, 0, 8'h00, 0, 0, 4, 1, 1, 0, 2};
    tbl[9]  = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 1, 1, 3};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 0, 1, 4, 1, 1, 1, 3};
    tbl[11] = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 0, 0, 0};
    tbl[12] = '{1, 8'h30, 1, 8'h40, 0, 0, 4, 1, 0, 0, 0};
    tbl[13] = '{0, 8'h00, 0, 8'h00, 1, 0, 4, 1, 0, 0, 0};
    tbl[14] = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 0, 0, 0};
    tbl[15] = '{0, 8'h00, 0, 8'h00, 0, 0, 4, 1, 0, 0, 0};
    ddr_valid = 1; ddr_data = 8'h11;
    #2;
    chk("init_valid", 32'(m_valid), 0);
    chk("init_data", 32'(m_data), 0);
    chk("init_count", 32'(count), 0);
    chk("init_flags", 32'({ovf, mis}), 0);
    #20;
    ddr_data = 8'h22;
    arst_n = 1;
    step(1, 8'h11, 1, 8'h22, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    chk("first_valid", 32'(m_valid), 1);
    chk("first_data", 32'(m_data), 32'h2211);
    chk("first_mis", 32'(mis), 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].va, tbl[i].a, tbl[i].vb, tbl[i].b, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_mis", i), 32'(mis), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), CNT_EN ? 32'(tbl[i].drop) : 32'd0);
      if (i == 7) chk("ovf_head_data", 32'(m_data), 32'h2010);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 8'h00, 1, 0);
    chk("drained", 32'(count), 0);
    for (int i = 0; i < 10; i++) begin
      step(i < 8, 8'(8'h50 + i), i < 8, 8'(8'h60 + i), 1, 0);
      chk("stream_count_le1", 32'(count <= 1), 1);
      chk("stream_flags", 32'({ovf, mis}), 0);
    end
    for (int i = 0; i < 400; i++) begin
      bit va, vb;
      va = $urandom_range(0, 9) != 0;
      vb = ($urandom_range(0, 9) != 0) ? va : ~va;
      step(va, 8'($urandom), vb, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 8'h00, 1, 1);
    for (int i = 0; i < 5; i++) step(i < 3, 8'(8'h70 + i), i < 3, 8'(8'h80 + i), 0, 0);
    chk("pre_reset_count", 32'(count), 3);
    do_reset();
    for (int i = 0; i < 8; i++) step(i < 5, 8'(8'h90 + i), i < 5, 8'(8'hA0 + i), 1, 0);
    chk("post_reset_last", 32'(m_data), 32'hA494);
    chk("post_reset_mis", 32'(mis), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
